// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: turns a single-bit spike train into a windowed,
// saturating rate code and an inter-spike interval measurement.
module spike_rate_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [CNT_W-1:0] win_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic [CNT_W-1:0] isi_out,
    output logic             isi_valid,
    output logic             rate_sat
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] MAX_VAL  = '1;
    localparam logic [CNT_W:0]   FULL_WIN = {1'b1, {CNT_W{1'b0}}};

    state_t           state_q;
    logic             spk_q;
    logic             have_prev_q;
    logic [CNT_W-1:0] win_cnt_q;
    logic [CNT_W-1:0] isi_cnt_q;
    logic [CNT_W:0]   win_lim_q;
    logic [CNT_W:0]   spk_cnt_q;
    logic [CNT_W-1:0] rate_q;
    logic [CNT_W-1:0] isi_q;
    logic             rate_valid_q;
    logic             isi_valid_q;
    logic             rate_sat_q;

    logic             spk_edge;
    logic             win_last;
    logic [CNT_W:0]   win_lim_d;
    logic [CNT_W:0]   spk_tot;
    logic [CNT_W:0]   spk_cnt_d;
    logic [CNT_W-1:0] rate_d;
    logic [CNT_W-1:0] isi_inc;

    // The window length is sampled live on the first cycle of every window
    // (including the cycle enable first rises), then held until the window closes.
    // The spike count saturates one above MAX_VAL so an overflow stays visible.
    always_comb begin
        spk_edge = spike_in & ~spk_q;
        if (state_q == IDLE || win_cnt_q == '0) begin
            win_lim_d = (win_len == '0) ? FULL_WIN : {1'b0, win_len};
        end else begin
            win_lim_d = win_lim_q;
        end
        win_last  = ({1'b0, win_cnt_q} == win_lim_d - 1'b1);
        spk_tot   = spk_cnt_q + {{CNT_W{1'b0}}, spk_edge};
        spk_cnt_d = (spk_tot > FULL_WIN) ? FULL_WIN : spk_tot;
        rate_d    = (spk_tot > {1'b0, MAX_VAL}) ? MAX_VAL : spk_tot[CNT_W-1:0];
        isi_inc   = (isi_cnt_q == MAX_VAL) ? MAX_VAL : isi_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            spk_q        <= 1'b0;
            have_prev_q  <= 1'b0;
            win_cnt_q    <= '0;
            isi_cnt_q    <= '0;
            win_lim_q    <= '0;
            spk_cnt_q    <= '0;
            rate_q       <= '0;
            isi_q        <= '0;
            rate_valid_q <= 1'b0;
            isi_valid_q  <= 1'b0;
            rate_sat_q   <= 1'b0;
        end else begin
            spk_q        <= spike_in;
            rate_valid_q <= 1'b0;
            isi_valid_q  <= 1'b0;
            if (!enable) begin
                state_q     <= IDLE;
                have_prev_q <= 1'b0;
                win_cnt_q   <= '0;
                spk_cnt_q   <= '0;
                isi_cnt_q   <= '0;
            end else begin
                state_q   <= RUN;
                win_lim_q <= win_lim_d;
                if (win_last) begin
                    rate_q       <= rate_d;
                    rate_valid_q <= 1'b1;
                    if (spk_tot > {1'b0, MAX_VAL}) begin
                        rate_sat_q <= 1'b1;
                    end
                    win_cnt_q <= '0;
                    spk_cnt_q <= '0;
                end else begin
                    win_cnt_q <= win_cnt_q + 1'b1;
                    spk_cnt_q <= spk_cnt_d;
                end
                // Interval tracking ignores window boundaries entirely.
                if (spk_edge) begin
                    if (have_prev_q) begin
                        isi_q       <= isi_inc;
                        isi_valid_q <= 1'b1;
                    end
                    isi_cnt_q   <= '0;
                    have_prev_q <= 1'b1;
                end else begin
                    isi_cnt_q <= isi_inc;
                end
            end
        end
    end

    assign rate_out   = rate_q;
    assign rate_valid = rate_valid_q;
    assign isi_out    = isi_q;
    assign isi_valid  = isi_valid_q;
    assign rate_sat   = rate_sat_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed scenarios plus random
// traffic, compared every cycle against a timestamp-based reference model.
module tb_spike_rate_decoder;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       spike_in;
    logic [7:0] win_len;
    logic [7:0] rate_out;
    logic       rate_valid;
    logic [7:0] isi_out;
    logic       isi_valid;
    logic       rate_sat;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: absolute timestamps and plain integer counts.
    bit mPrevSpk  = 0;
    bit mRun      = 0;
    int mWinStart = 0;
    int mWinN     = 0;
    int mCount    = 0;
    int mLastEdge = -1;
    int expRate   = 0;
    int expIsi    = 0;
    bit expRv     = 0;
    bit expIv     = 0;
    bit expSat    = 0;

    spike_rate_decoder #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .spike_in   (spike_in),
        .win_len    (win_len),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .isi_out    (isi_out),
        .isi_valid  (isi_valid),
        .rate_sat   (rate_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, observed, expected);
        end
    endtask

    // Advances the model by one clock cycle given that cycle's inputs; the
    // exp* values are what the outputs should show after the clock edge.
    task automatic modelStep(input bit r, input bit e, input bit s, input int wl);
        bit isEdge;
        expRv = 0;
        expIv = 0;
        if (r) begin
            mPrevSpk  = 0;
            mRun      = 0;
            mLastEdge = -1;
            expRate   = 0;
            expIsi    = 0;
            expSat    = 0;
            return;
        end
        isEdge   = s && !mPrevSpk;
        mPrevSpk = s;
        if (!e) begin
            mRun      = 0;
            mLastEdge = -1;
            return;
        end
        if (!mRun) begin
            mRun      = 1;
            mWinStart = cyc;
        end
        if (cyc == mWinStart) begin
            mWinN  = ((wl & 255) == 0) ? 256 : (wl & 255);
            mCount = 0;
        end
        if (isEdge) mCount++;
        if (cyc - mWinStart == mWinN - 1) begin
            expRate   = (mCount > 255) ? 255 : mCount;
            expRv     = 1;
            if (mCount > 255) expSat = 1;
            mWinStart = cyc + 1;
        end
        if (isEdge) begin
            if (mLastEdge >= 0) begin
                expIsi = ((cyc - mLastEdge) > 255) ? 255 : (cyc - mLastEdge);
                expIv  = 1;
            end
            mLastEdge = cyc;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit s, input int wl);
        @(negedge clk);
        rst      = r;
        enable   = e;
        spike_in = s;
        win_len  = wl[7:0];
        @(posedge clk);
        #1;
        modelStep(r, e, s, wl);
        checkOutput("rate_valid", int'(rate_valid), int'(expRv));
        checkOutput("isi_valid",  int'(isi_valid),  int'(expIv));
        checkOutput("rate_out",   int'(rate_out),   expRate);
        checkOutput("isi_out",    int'(isi_out),    expIsi);
        checkOutput("rate_sat",   int'(rate_sat),   int'(expSat));
        cyc++;
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        spike_in = 1'b0;
        win_len  = 8'd10;

        // Reset held with spikes toggling, then idle with enable low.
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, i[0], 10);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, i[0], 10);

        // 10-cycle windows, edge on the last cycle of the first window.
        for (int i = 0; i < 25; i++) applyStimulus(0, 1, (i == 1 || i == 4 || i == 9), 10);
        applyStimulus(0, 0, 0, 10);

        // Interval measurement including saturation, with 256-cycle windows.
        for (int i = 0; i < 310; i++) applyStimulus(0, 1, (i == 2 || i == 7 || i == 300), 0);
        applyStimulus(0, 0, 0, 0);

        // Level held high is a single edge.
        for (int i = 0; i < 40; i++) applyStimulus(0, 1, (i >= 5 && i <= 20), 30);
        applyStimulus(0, 0, 0, 30);

        // Window length change mid-window applies from the next window.
        for (int i = 0; i < 40; i++) applyStimulus(0, 1, (i % 3 == 0), (i < 5) ? 10 : 4);
        applyStimulus(0, 0, 0, 10);

        // Enable dropped mid-window and raised again.
        for (int i = 0; i < 30; i++)
            applyStimulus(0, !(i >= 6 && i < 12), (i == 2 || i == 4 || i == 14 || i == 17), 10);

        // Random traffic with occasional resets and enable drops.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit e;
            bit s;
            int wl;
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 24) != 0);
            s  = (i % 500 < 250) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            wl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
            applyStimulus(r, e, s, wl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
